i2s_tx_24: RTL

- I²S master transmitter.
- Generates SCK and WS from the system clock and serialises 24-bit left/right sample pairs into standard I²S 32-bit slots, MSB delayed one SCK after each WS edge.
- Acts as the transmit end facing i2s_capture_24 (DAC/loopback path).
- Takes sample pairs through a valid/ready handshake into a one-entry holding buffer.

---
 rtl/i2s_tx_24.sv | 112 +++++++++++
 1 files changed

// File: rtl/i2s_tx_24.sv
// I2S master transmitter: divides clk into SCK/WS and shifts 24-bit L/R pairs
// into 32-bit slots with the MSB one SCK after each WS edge.
module i2s_tx_24 #(
   parameter int SCK_DIV = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [23:0] left_i,
   input  logic [23:0] right_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic        sck_o,
   output logic        ws_o,
   output logic        sd_o,
   output logic        underrun_o
);
   localparam int DW = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;

   logic [DW-1:0] div_q, div_d;
   logic          sck_q, sck_d;
   logic [5:0]    c_q, c_d;
   logic          ws_q, ws_d, sd_q, sd_d;
   logic [23:0]   lsr_q, lsr_d, rsr_q, rsr_d;
   logic [23:0]   bl_q, bl_d, br_q, br_d;
   logic          full_q, full_d, ready_q, ready_d, und_q, und_d;
   logic          tick, fall, load, acc;

   always_comb begin
      div_d   = div_q;
      sck_d   = sck_q;
      c_d     = c_q;
      ws_d    = ws_q;
      sd_d    = sd_q;
      lsr_d   = lsr_q;
      rsr_d   = rsr_q;
      bl_d    = bl_q;
      br_d    = br_q;
      full_d  = full_q;
      und_d   = 1'b0;
      tick    = (div_q == DW'(SCK_DIV - 1));
      fall    = tick && sck_q;
      load    = fall && (c_q == 6'd63);
      acc     = valid_i && !full_q;

      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) sck_d = ~sck_q;

      // WS/SD only move on the SCK falling clk so a rising-edge receiver sees
      // half a bit period of setup and hold.
      if (fall) begin
         c_d  = c_q + 6'd1;
         ws_d = c_d[5];
         sd_d = 1'b0;
         if (load) begin
            lsr_d  = full_q ? bl_q : 24'd0;
            rsr_d  = full_q ? br_q : 24'd0;
            und_d  = !full_q;
            full_d = 1'b0;
         end else if (c_d >= 6'd1 && c_d <= 6'd24) begin
            sd_d  = lsr_q[23];
            lsr_d = {lsr_q[22:0], 1'b0};
         end else if (c_d >= 6'd33 && c_d <= 6'd56) begin
            sd_d  = rsr_q[23];
            rsr_d = {rsr_q[22:0], 1'b0};
         end
      end

      // A load only clears a full buffer, so it can never race an accept.
      if (acc) begin
         bl_d   = left_i;
         br_d   = right_i;
         full_d = 1'b1;
      end
      ready_d = !full_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q   <= '0;
         sck_q   <= 1'b0;
         c_q     <= 6'd63;
         ws_q    <= 1'b1;
         sd_q    <= 1'b0;
         lsr_q   <= 24'd0;
         rsr_q   <= 24'd0;
         bl_q    <= 24'd0;
         br_q    <= 24'd0;
         full_q  <= 1'b0;
         ready_q <= 1'b1;
         und_q   <= 1'b0;
      end else begin
         div_q   <= div_d;
         sck_q   <= sck_d;
         c_q     <= c_d;
         ws_q    <= ws_d;
         sd_q    <= sd_d;
         lsr_q   <= lsr_d;
         rsr_q   <= rsr_d;
         bl_q    <= bl_d;
         br_q    <= br_d;
         full_q  <= full_d;
         ready_q <= ready_d;
         und_q   <= und_d;
      end
   end

   assign ready_o    = ready_q;
   assign sck_o      = sck_q;
   assign ws_o       = ws_q;
   assign sd_o       = sd_q;
   assign underrun_o = und_q;
endmodule
